// File: rtl/wb_bus_decoder_pkg.sv
// Shared definitions for the Wishbone bus decoder: bus widths, slave
// region map, slave indices, FSM states and the latched request payload.
package wb_bus_decoder_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned N_SLAVES = 3;
  localparam int unsigned SEL_W    = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // Slave indices; bit position in the one-hot slave strobe
  localparam sel_t SLV_BOOTROM = SEL_W'(0);
  localparam sel_t SLV_RAM     = SEL_W'(1);
  localparam sel_t SLV_IO      = SEL_W'(2);

  // Region match: (addr & MASK) == BASE
  localparam logic [ADDR_W-1:0] BOOTROM_BASE = 32'hb000_0000;
  localparam logic [ADDR_W-1:0] BOOTROM_MASK = 32'hffff_8000;
  localparam logic [ADDR_W-1:0] RAM_BASE     = 32'hb000_8000;
  localparam logic [ADDR_W-1:0] RAM_MASK     = 32'hffff_8000;
  localparam logic [ADDR_W-1:0] IO_BASE      = 32'hc000_0000;
  localparam logic [ADDR_W-1:0] IO_MASK      = 32'hffff_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Master request captured on accept
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              we;
  } wb_req_t;

  // Slave index to one-hot strobe; out-of-range index selects nobody
  function automatic logic [N_SLAVES-1:0] sel_onehot(input sel_t sel);
    logic [N_SLAVES-1:0] oh;
    oh = '0;
    case (sel)
      SLV_BOOTROM: oh = 3'b001;
      SLV_RAM:     oh = 3'b010;
      SLV_IO:      oh = 3'b100;
      default:     oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/wb_addr_map.sv
// Combinational address decoder.
// Ports:
//   addr        - master byte address
//   mapped_c    - address falls inside one of the slave regions
//   slave_idx_c - index of the matching slave (bootrom when unmapped)
module wb_addr_map
  import wb_bus_decoder_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic              mapped_c,
  output sel_t              slave_idx_c
);

  always_comb begin
    mapped_c    = 1'b1;
    slave_idx_c = SLV_BOOTROM;
    if ((addr & BOOTROM_MASK) == BOOTROM_BASE) begin
      slave_idx_c = SLV_BOOTROM;
    end else if ((addr & RAM_MASK) == RAM_BASE) begin
      slave_idx_c = SLV_RAM;
    end else if ((addr & IO_MASK) == IO_BASE) begin
      slave_idx_c = SLV_IO;
    end else begin
      mapped_c = 1'b0;
    end
  end

endmodule

// File: rtl/wb_bus_decoder.sv
// Pipelined Wishbone master-to-slave decoder with one outstanding
// transaction, per-transaction timeout and error/exception reporting.
// Ports:
//   clk, reset                      - clock, async active-low reset
//   i_wb_cyc/stb/we/addr/data       - master request
//   o_wb_data/ack/err/stall         - master response
//   o_s_cyc/we/addr/data, o_s_stb   - shared slave bus, one-hot strobe
//   i_s_ack/stall/data              - per-slave responses (slave k at [32k+31:32k])
//   o_exception, o_err_addr         - error pulse and last failed address
module wb_bus_decoder
  import wb_bus_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_wb_cyc,
  input  logic                       i_wb_stb,
  input  logic                       i_wb_we,
  input  logic [ADDR_W-1:0]          i_wb_addr,
  input  logic [DATA_W-1:0]          i_wb_data,
  output logic [DATA_W-1:0]          o_wb_data,
  output logic                       o_wb_ack,
  output logic                       o_wb_err,
  output logic                       o_wb_stall,
  output logic                       o_s_cyc,
  output logic                       o_s_we,
  output logic [ADDR_W-1:0]          o_s_addr,
  output logic [DATA_W-1:0]          o_s_data,
  output logic [N_SLAVES-1:0]        o_s_stb,
  input  logic [N_SLAVES-1:0]        i_s_ack,
  input  logic [N_SLAVES-1:0]        i_s_stall,
  input  logic [N_SLAVES*DATA_W-1:0] i_s_data,
  output logic                       o_exception,
  output logic [ADDR_W-1:0]          o_err_addr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  wb_req_t             req_q, req_d;
  sel_t                sel_q, sel_d;

  logic                map_hit_c;
  sel_t                map_idx_c;
  logic                sel_ack_c;
  logic                sel_stall_c;
  logic [DATA_W-1:0]   sel_rdata_c;

  logic                ack_d;
  logic                err_d;
  logic                stall_d;
  logic                cyc_d;
  logic                we_d;
  logic [N_SLAVES-1:0] stb_d;
  logic [DATA_W-1:0]   rdata_d;
  logic [ADDR_W-1:0]   err_addr_d;

  wb_addr_map u_addr_map (
    .addr        (i_wb_addr),
    .mapped_c    (map_hit_c),
    .slave_idx_c (map_idx_c)
  );

  // Pick out the responses of the currently selected slave
  always_comb begin
    sel_ack_c   = 1'b0;
    sel_stall_c = 1'b0;
    sel_rdata_c = '0;
    for (int k = 0; k < int'(N_SLAVES); k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_ack_c   = i_s_ack[k];
        sel_stall_c = i_s_stall[k];
        sel_rdata_c = i_s_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    sel_d      = sel_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdata_d    = o_wb_data;
    err_addr_d = o_err_addr;

    case (state_q)
      ST_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          req_d.addr = i_wb_addr;
          req_d.data = i_wb_data;
          req_d.we   = i_wb_we;
          sel_d      = map_idx_c;
          cnt_d      = '0;
          if (map_hit_c) begin
            state_d = ST_REQ;
          end else begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_addr_d = i_wb_addr;
          end
        end
      end
      ST_REQ, ST_WAIT: begin
        // Abort beats ack beats timeout; an ack in REQ counts only
        // if the slave took the strobe in that same cycle
        if (!i_wb_cyc) begin
          state_d = ST_IDLE;
        end else if (sel_ack_c && (state_q == ST_WAIT || !sel_stall_c)) begin
          state_d = ST_IDLE;
          ack_d   = 1'b1;
          rdata_d = sel_rdata_c;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d    = ST_ERR;
          err_d      = 1'b1;
          err_addr_d = req_q.addr;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (state_q == ST_REQ && !sel_stall_c) begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cyc_d   = 1'b0;
    we_d    = 1'b0;
    stb_d   = '0;
    stall_d = (state_d != ST_IDLE);
    if (state_d == ST_REQ || state_d == ST_WAIT) begin
      cyc_d = 1'b1;
      we_d  = req_d.we;
    end
    if (state_d == ST_REQ) begin
      stb_d = sel_onehot(sel_d);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      sel_q       <= SLV_BOOTROM;
      o_wb_ack    <= 1'b0;
      o_wb_err    <= 1'b0;
      o_wb_stall  <= 1'b0;
      o_wb_data   <= '0;
      o_exception <= 1'b0;
      o_err_addr  <= '0;
      o_s_cyc     <= 1'b0;
      o_s_we      <= 1'b0;
      o_s_stb     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      sel_q       <= sel_d;
      o_wb_ack    <= ack_d;
      o_wb_err    <= err_d;
      o_wb_stall  <= stall_d;
      o_wb_data   <= rdata_d;
      o_exception <= err_d;
      o_err_addr  <= err_addr_d;
      o_s_cyc     <= cyc_d;
      o_s_we      <= we_d;
      o_s_stb     <= stb_d;
    end
  end

  // Slave address/data come straight from the request latch
  assign o_s_addr = req_q.addr;
  assign o_s_data = req_q.data;

endmodule

// File: tb/tb_wb_bus_decoder.sv
// Directed bench for wb_bus_decoder with a transaction-level reference model.
module tb_wb_bus_decoder;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [31:0] wb_addr = '0, wb_data = '0;
  logic [31:0] wb_rdata;
  logic        wb_ack, wb_err, wb_stall;
  logic        s_cyc, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [2:0]  s_stb;
  logic [2:0]  s_ack = '0, s_stall = '0;
  logic [95:0] s_data = '0;
  logic        exc;
  logic [31:0] err_addr;

  wb_bus_decoder #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (rst),
    .i_wb_cyc    (wb_cyc),
    .i_wb_stb    (wb_stb),
    .i_wb_we     (wb_we),
    .i_wb_addr   (wb_addr),
    .i_wb_data   (wb_data),
    .o_wb_data   (wb_rdata),
    .o_wb_ack    (wb_ack),
    .o_wb_err    (wb_err),
    .o_wb_stall  (wb_stall),
    .o_s_cyc     (s_cyc),
    .o_s_we      (s_we),
    .o_s_addr    (s_addr),
    .o_s_data    (s_wdata),
    .o_s_stb     (s_stb),
    .i_s_ack     (s_ack),
    .i_s_stall   (s_stall),
    .i_s_data    (s_data),
    .o_exception (exc),
    .o_err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int region(input logic [31:0] a);
    if (a >= 32'hb000_0000 && a <= 32'hb000_7fff) return 0;
    if (a >= 32'hb000_8000 && a <= 32'hb000_ffff) return 1;
    if (a >= 32'hc000_0000 && a <= 32'hc000_ffff) return 2;
    return -1;
  endfunction

  bit          m_busy, m_issued, m_errc, m_we;
  int          m_age, m_sel;
  logic [31:0] m_addr, m_data;
  bit          e_ack, e_err;
  logic [31:0] e_rdata, e_err_addr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_issued = 0; m_errc = 0; m_we = 0; m_age = 0; m_sel = 0;
      m_addr = '0; m_data = '0;
      e_ack = 0; e_err = 0; e_rdata = '0; e_err_addr = '0;
    end else begin
      e_ack = 0;
      e_err = 0;
      if (m_errc) begin
        m_errc = 0;
      end else if (!m_busy) begin
        if (wb_cyc && wb_stb) begin
          m_addr = wb_addr;
          m_data = wb_data;
          m_we   = wb_we;
          m_sel  = region(wb_addr);
          if (m_sel < 0) begin
            m_sel = 0; e_err = 1; e_err_addr = wb_addr; m_errc = 1;
          end else begin
            m_busy = 1; m_issued = 0; m_age = 0;
          end
        end
      end else begin
        if (!wb_cyc) begin
          m_busy = 0;
        end else if (s_ack[m_sel] && (m_issued || !s_stall[m_sel])) begin
          e_ack = 1; e_rdata = s_data[m_sel*32 +: 32]; m_busy = 0;
        end else if (m_age + 1 >= TIMEOUT) begin
          e_err = 1; e_err_addr = m_addr; m_errc = 1; m_busy = 0;
        end else begin
          m_age++;
          if (!s_stall[m_sel]) m_issued = 1;
        end
      end
    end
  end

  // ---------------- compare + monitor ----------------
  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  int ack_cnt, err_cnt, exc_cnt, stb1_cnt, stb_any_cnt, we_stb_cnt;
  int last_ack_cyc, last_err_cyc;
  logic [31:0] last_ack_data;

  always @(negedge clk) begin
    logic [2:0] e_stb;
    e_stb = (m_busy && !m_issued) ? (3'b001 << m_sel) : 3'b000;
    check("wb_ack",   32'(wb_ack),   32'(e_ack));
    check("wb_err",   32'(wb_err),   32'(e_err));
    check("exc",      32'(exc),      32'(e_err));
    check("wb_stall", 32'(wb_stall), 32'(m_busy | m_errc));
    check("wb_data",  wb_rdata,      e_rdata);
    check("err_addr", err_addr,      e_err_addr);
    check("s_stb",    32'(s_stb),    32'(e_stb));
    check("s_cyc",    32'(s_cyc),    32'(m_busy));
    check("s_we",     32'(s_we),     32'(m_busy & m_we));
    check("s_addr",   s_addr,        m_addr);
    check("s_data",   s_wdata,       m_data);
    check("ack_err_excl", 32'(wb_ack & wb_err), 32'd0);
    if (wb_ack) begin ack_cnt++; last_ack_cyc = cyc_n; last_ack_data = wb_rdata; end
    if (wb_err) begin err_cnt++; last_err_cyc = cyc_n; end
    if (exc) exc_cnt++;
    if (s_stb[1]) stb1_cnt++;
    if (s_stb != 3'b000) stb_any_cnt++;
    if (s_stb != 3'b000 && s_we) we_stb_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    ack_cnt = 0; err_cnt = 0; exc_cnt = 0; stb1_cnt = 0; stb_any_cnt = 0; we_stb_cnt = 0;
    last_ack_cyc = -1; last_err_cyc = -1; last_ack_data = '0;
  endtask

  task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d);
    wb_cyc = 1; wb_stb = 1; wb_we = w; wb_addr = a; wb_data = d;
  endtask

  int n;

  initial begin
    clr();
    repeat (3) tick();
    check("rst_stall", 32'(wb_stall), 32'd0);
    check("rst_stb",   32'(s_stb),    32'd0);
    rst = 1;
    tick();

    // Read bootrom, ack one cycle after strobe
    clr(); n = cyc_n;
    req(32'hb000_0010, 0, '0);
    tick();                                   // N+1: REQ
    wb_stb = 0; s_ack = 3'b100;               // ack from wrong slave
    tick();                                   // N+2: WAIT
    s_ack = 3'b001; s_data = {64'h0, 32'hdeadbeef};
    tick();                                   // N+3: ack
    s_ack = 0;
    tick(); wb_cyc = 0; tick(); tick();
    check("rd0_ack_cycle", 32'(last_ack_cyc), 32'(n + 3));
    check("rd0_data",      last_ack_data,     32'hdeadbeef);
    check("rd0_ack_count", 32'(ack_cnt),      32'd1);
    check("rd0_stb_cycles", 32'(stb_any_cnt), 32'd1);

    // Write RAM, slave stalls two cycles
    clr(); n = cyc_n;
    req(32'hb000_8004, 1, 32'h1234_5678);
    tick();                                   // N+1
    wb_stb = 0; wb_we = 0; s_stall = 3'b010;
    tick(); tick();                           // N+3
    s_stall = 0;
    tick();                                   // N+4: WAIT
    s_ack = 3'b010; s_data = {32'h0, 32'hcafe_f00d, 32'h0};
    tick();                                   // N+5: ack
    s_ack = 0;
    tick(); wb_cyc = 0; tick(); tick();
    check("wr1_stb_cycles", 32'(stb1_cnt),    32'd3);
    check("wr1_we_cycles",  32'(we_stb_cnt),  32'd3);
    check("wr1_ack_count",  32'(ack_cnt),     32'd1);
    check("wr1_ack_cycle",  32'(last_ack_cyc), 32'(n + 5));

    // Unmapped read
    clr(); n = cyc_n;
    req(32'ha000_0000, 0, '0);
    tick();                                   // N+1: ERR
    wb_stb = 0; tick(); wb_cyc = 0; tick();
    check("unm_err_cycle", 32'(last_err_cyc), 32'(n + 1));
    check("unm_err_count", 32'(err_cnt),      32'd1);
    check("unm_exc_count", 32'(exc_cnt),      32'd1);
    check("unm_no_stb",    32'(stb_any_cnt),  32'd0);
    check("unm_err_addr",  err_addr,          32'ha000_0000);

    // IO read, slave never acks
    clr(); n = cyc_n;
    req(32'hc000_0000, 0, '0);
    tick(); wb_stb = 0;
    repeat (18) tick();                       // N+19
    check("to_err_cycle", 32'(last_err_cyc), 32'(n + TIMEOUT + 1));
    s_ack = 3'b100; s_data = {32'h1111_2222, 64'h0};
    tick(); s_ack = 0; tick();
    check("to_err_count",  32'(err_cnt), 32'd1);
    check("to_stray_ack",  32'(ack_cnt), 32'd0);
    check("to_err_addr",   err_addr,     32'hc000_0000);
    wb_cyc = 0; tick();

    // Ack in REQ together with stall=0
    clr(); n = cyc_n;
    req(32'hb000_fffc, 0, '0);
    tick();                                   // N+1: REQ
    wb_stb = 0; s_ack = 3'b010; s_data = {32'h0, 32'h0bad_f00d, 32'h0};
    tick();                                   // N+2: ack
    s_ack = 0; tick(); wb_cyc = 0; tick();
    check("fast_ack_cycle", 32'(last_ack_cyc), 32'(n + 2));
    check("fast_ack_data",  last_ack_data,     32'h0bad_f00d);

    // Master drops cyc while waiting
    clr();
    req(32'hc000_0100, 0, '0);
    tick(); wb_stb = 0;                       // REQ
    tick(); wb_cyc = 0;                       // WAIT
    tick();
    check("abort_cyc",   32'(s_cyc),    32'd0);
    check("abort_stb",   32'(s_stb),    32'd0);
    check("abort_stall", 32'(wb_stall), 32'd0);
    s_ack = 3'b100; tick(); s_ack = 0; tick();
    check("abort_ack", 32'(ack_cnt), 32'd0);
    check("abort_err", 32'(err_cnt), 32'd0);

    // Reset asserted while strobing
    clr();
    req(32'hb000_0020, 1, 32'h55aa_55aa);
    tick(); wb_stb = 0;                       // REQ
    check("rr_stb_before", 32'(s_stb), 32'd1);
    rst = 0; #1;
    check("rr_stb_now", 32'(s_stb), 32'd0);
    check("rr_cyc_now", 32'(s_cyc), 32'd0);
    check("rr_we_now",  32'(s_we),  32'd0);
    tick(); rst = 1; s_ack = 3'b001;
    tick(); s_ack = 0; wb_cyc = 0; tick(); tick();
    check("rr_ack", 32'(ack_cnt), 32'd0);
    check("rr_err", 32'(err_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_bus_decoder.md
WB_BUS_DECODER -- requirements
Module: wb_bus_decoder

Interface
REQ-001 Parameter TIMEOUT, default 16: cycles allowed from slave request to slave ack before an error response.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 i_wb_cyc, i_wb_stb, i_wb_we  input  1 each  master (CPU) pipelined Wishbone cycle, strobe, write-enable.
REQ-005 i_wb_addr  input  32  master byte address; i_wb_data  input  32  master write data.
REQ-006 o_wb_data  output  32  read data to master; o_wb_ack, o_wb_err, o_wb_stall  output  1 each.
REQ-007 o_s_cyc, o_s_we  output  1 each; o_s_addr  output  32; o_s_data  output  32  shared slave bus.
REQ-008 o_s_stb  output  3  one-hot slave strobe: bit0 bootrom, bit1 internal RAM, bit2 IO.
REQ-009 i_s_ack, i_s_stall  input  3 each  per-slave ack/stall; i_s_data  input  96  slave k read data at [32k+31:32k].
REQ-010 o_exception  output  1  one-cycle pulse on any error response; o_err_addr  output  32  address of last failed access.

Function
REQ-011 Map: 0xb0000000-0xb0007fff slave 0; 0xb0008000-0xb000ffff slave 1; 0xc0000000-0xc000ffff slave 2; any other address unmapped.
REQ-012 FSM states IDLE, REQ, WAIT, ERR; one outstanding transaction at a time.
REQ-013 o_wb_stall SHALL be 0 only in IDLE; request accepted when IDLE && i_wb_cyc && i_wb_stb.
REQ-014 On accept: latch addr, data, we, decoded slave index; mapped -> REQ, unmapped -> ERR.
REQ-015 REQ: o_s_stb bit of selected slave = 1, o_s_addr/o_s_data/o_s_we driven from latches; if i_s_stall[sel]=0 -> WAIT, else hold REQ.
REQ-016 WAIT: o_s_stb = 0; on i_s_ack[sel]=1, next cycle o_wb_ack=1 for exactly one cycle with o_wb_data = latched slice of i_s_data[sel]; -> IDLE.
REQ-017 An ack arriving in REQ in the same cycle as stall=0 SHALL be honoured as in WAIT.
REQ-018 o_s_cyc = 1 in REQ and WAIT only.
REQ-019 ERR: o_wb_err=1, o_exception=1 for exactly one cycle, o_err_addr updated; -> IDLE.
REQ-020 Timeout counter cleared on entering REQ, increments each cycle in REQ/WAIT; reaching TIMEOUT without ack -> ERR, o_s_stb/o_s_cyc dropped.
REQ-021 Acks from non-selected slaves, or any ack while IDLE/ERR, SHALL be ignored.
REQ-022 i_wb_cyc deasserted in REQ or WAIT: abort to IDLE next cycle, no ack, no err, no exception.
REQ-023 Minimum read latency: accept at cycle N, o_s_stb at N+1, slave ack at N+2, o_wb_ack at N+3.
REQ-024 o_wb_ack and o_wb_err SHALL never be asserted together.

Reset
REQ-025 While reset=0: state IDLE, counter 0, o_wb_ack/o_wb_err/o_exception/o_s_stb/o_s_cyc/o_s_we = 0, o_wb_data/o_err_addr/o_s_addr/o_s_data = 0.
REQ-026 Reset asserted mid-transaction SHALL drop all slave strobes immediately and produce no master response.

Structure
REQ-027 Shared package holds the region base/mask constants, slave index constants, and the FSM state enumeration.
REQ-028 One sub-module, wb_addr_map: purely combinational address -> {mapped, slave index} decode.

Verification
REQ-029 Read 0xb0000010, slave 0 acks 1 cycle after strobe with 0xdeadbeef -> o_wb_ack at N+3, o_wb_data=0xdeadbeef.
REQ-030 Write 0xb0008004 data 0x12345678, slave 1 stalls 2 cycles -> o_s_stb[1] held 3 cycles, o_s_we=1, single o_wb_ack.
REQ-031 Read 0xa0000000 -> o_wb_err and o_exception one cycle at N+1, o_err_addr=0xa0000000, no o_s_stb.
REQ-032 Read 0xc0000000, slave 2 never acks -> o_wb_err exactly TIMEOUT+1 cycles after accept, later stray ack ignored.
REQ-033 i_wb_cyc dropped during WAIT, and separately reset asserted in REQ -> IDLE, no ack/err, o_s_stb=0.
